// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encoding, line geometry and the field-width helper.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = LINE_BYTES * 8;
  localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);
  localparam int LINE_LSB       = $clog2(LINE_BYTES);

  // A line viewed as an array of words; word 0 sits in bits [31:0].
  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

  // Tag width left over once the line offset and index are removed.
  function automatic int tag_width(input int addr_bits, input int num_blocks);
    return addr_bits - LINE_LSB - $clog2(num_blocks);
  endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// PC-unit and instruction-memory signals of the instruction cache.
// master = PC unit plus instruction memory, slave = the cache itself.
// Optional macro ICACHE_STATS_EN adds the HIT_COUNT/MISS_COUNT outputs.
interface instruction_cache_if
  import icache_pkg::*;
#(
  parameter int ADDR_BITS = 10
);

  logic [31:0]               PC;
  logic [31:0]               INSTRUCTION;
  logic                      BUSYWAIT;
  logic                      MEM_READ;
  logic [ADDR_BITS-LINE_LSB-1:0] MEM_ADDRESS;
  logic [LINE_W-1:0]         MEM_READDATA;
  logic                      MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]               HIT_COUNT;
  logic [15:0]               MISS_COUNT;

  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
  );

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
  );
`else
  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
`endif

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage of the instruction cache: one synchronous write
// port for line fills, combinational lookup returning hit and the word.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int TAG_W      = 3,
  localparam int IDX_W     = $clog2(NUM_BLOCKS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_index,
  input  logic [TAG_W-1:0]    rd_tag,
  input  logic [OFFSET_W-1:0] rd_offset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [TAG_W-1:0]    wr_tag,
  input  line_t               wr_data,
  output logic                hit,
  output logic [WORD_W-1:0]   rd_word
);

  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]      tags [NUM_BLOCKS];
  line_t                 lines[NUM_BLOCKS];

  // Clear every line on reset, otherwise store a completed fill.
  // NOTE: the whole array is reset (not just the valid bits) so the
  // instruction output reads 0 after reset; this keeps the storage in
  // flops rather than a RAM macro, which is fine at this size.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tags[i]  <= '0;
        lines[i] <= '0;
      end
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_data;
    end
  end

  assign hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
  assign rd_word = lines[rd_index][rd_offset];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: 16-byte lines, whole-line fills from
// instruction memory, BUSYWAIT stalls the PC unit during a miss.
// Optional macro ICACHE_STATS_EN adds saturating hit/miss counters.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic                CLK,
  input  logic                RESET,
  instruction_cache_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int TAG_W  = tag_width(ADDR_BITS, NUM_BLOCKS);
  localparam int FILL_W = ADDR_BITS - LINE_LSB;

  state_t              state;
  logic [FILL_W-1:0]   fill_addr;
  logic                mem_read;
  logic [FILL_W-1:0]   mem_address;
  logic                hit;
  logic                fill_done;
  logic [WORD_W-1:0]   rd_word;

  logic [OFFSET_W-1:0] offset;
  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic                unused_pc;

  assign offset    = bus.PC[LINE_LSB-1:2];
  assign index     = bus.PC[LINE_LSB+IDX_W-1:LINE_LSB];
  assign tag       = bus.PC[ADDR_BITS-1:LINE_LSB+IDX_W];
  assign unused_pc = ^{bus.PC[31:ADDR_BITS], bus.PC[1:0]};

  // The leaving edge of MEM_RD is the one that stores the line.
  assign fill_done = (state == MEM_RD) && !bus.MEM_BUSYWAIT;

  icache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk       (CLK),
    .rst       (RESET),
    .rd_index  (index),
    .rd_tag    (tag),
    .rd_offset (offset),
    .wr_en     (fill_done),
    .wr_index  (fill_addr[IDX_W-1:0]),
    .wr_tag    (fill_addr[FILL_W-1:IDX_W]),
    .wr_data   (line_t'(bus.MEM_READDATA)),
    .hit       (hit),
    .rd_word   (rd_word)
  );

  // Miss-handling FSM with registered memory request outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      fill_addr   <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state       <= MEM_RD;
            fill_addr   <= {tag, index};
            mem_read    <= 1'b1;
            mem_address <= {tag, index};
          end
        end
        MEM_RD: begin
          if (!bus.MEM_BUSYWAIT) begin
            state       <= UPDATE;
            mem_read    <= 1'b0;
            mem_address <= '0;
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_ADDRESS = mem_address;
  assign bus.INSTRUCTION = rd_word;
  assign bus.BUSYWAIT    = (state != IDLE) | ((state == IDLE) & ~hit);

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  // Saturating hit/miss counters; a miss counts on the IDLE->MEM_RD edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (hit && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (!hit && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

  assign bus.HIT_COUNT  = hit_count;
  assign bus.MISS_COUNT = miss_count;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: table of hit vectors plus
// hand-written miss, conflict, reset-mid-fill, long-stall and
// single-cycle-memory sequences. Stats checks only with ICACHE_STATS_EN.
module tb_instruction_cache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instruction_cache_if bus ();

  instruction_cache dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  localparam logic [127:0] D0 = 128'h0C0C0C0C_08080808_04040404_00000000;
  localparam logic [127:0] D1 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] D4 = 128'h44440003_44440002_44440001_44440000;
  localparam logic [127:0] D7 = 128'h7777000F_7777000E_7777000D_7777000C;

  typedef struct {
    logic [31:0] pc;
    logic        exp_busy;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] actual,
                       input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one line fill from the miss-detect cycle through to the IDLE hit.
  task automatic do_fill(input string name, input logic [5:0] exp_addr,
                         input int busy_cycles, input logic [127:0] data,
                         input bit wiggle);
    #1;
    check({name, " detect busywait"}, bus.BUSYWAIT, 1'b1);
    check({name, " detect mem_read"}, bus.MEM_READ, 1'b0);
    if (busy_cycles > 0) begin
      bus.MEM_BUSYWAIT = 1'b1;
      bus.MEM_READDATA = ~data;
    end else begin
      bus.MEM_BUSYWAIT = 1'b0;
      bus.MEM_READDATA = data;
    end
    step();
    for (int i = 0; i < busy_cycles; i++) begin
      if (wiggle) begin
        bus.PC = {bus.PC[31:2], 2'(i)};
        #1;
      end
      check({name, " wait mem_read"}, bus.MEM_READ, 1'b1);
      check({name, " wait mem_address"}, bus.MEM_ADDRESS, exp_addr);
      check({name, " wait busywait"}, bus.BUSYWAIT, 1'b1);
      step();
    end
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = data;
    #1;
    check({name, " last rd mem_read"}, bus.MEM_READ, 1'b1);
    check({name, " last rd mem_address"}, bus.MEM_ADDRESS, exp_addr);
    step();
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = '0;
    check({name, " update mem_read"}, bus.MEM_READ, 1'b0);
    check({name, " update mem_address"}, bus.MEM_ADDRESS, 6'h00);
    check({name, " update busywait"}, bus.BUSYWAIT, 1'b1);
    step();
    check({name, " idle busywait"}, bus.BUSYWAIT, 1'b0);
  endtask

  // Present one PC in IDLE, compare the hit outputs, then clock once.
  task automatic apply_vec(input string name, input vec_t v);
    bus.PC = v.pc;
    #1;
    check({name, " busywait"}, bus.BUSYWAIT, v.exp_busy);
    check({name, " instruction"}, bus.INSTRUCTION, v.exp_instr);
    check({name, " mem_read"}, bus.MEM_READ, 1'b0);
    check({name, " mem_address"}, bus.MEM_ADDRESS, 6'h00);
    step();
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, 32'h00000000};
    vecs[1] = '{32'h0000_0004, 1'b0, 32'h04040404};
    vecs[2] = '{32'h0000_0008, 1'b0, 32'h08080808};
    vecs[3] = '{32'h0000_000C, 1'b0, 32'h0C0C0C0C};
    vecs[4] = '{32'hFFFF_FC04, 1'b0, 32'h04040404};
    vecs[5] = '{32'h0000_000B, 1'b0, 32'h08080808};

    // Reset state with PC=0: everything cleared, so PC 0 misses.
    rst              = 1'b1;
    bus.PC           = 32'h0;
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = '0;
    step();
    step();
    check("reset mem_read", bus.MEM_READ, 1'b0);
    check("reset mem_address", bus.MEM_ADDRESS, 6'h00);
    check("reset instruction", bus.INSTRUCTION, 32'h0);
    check("reset busywait", bus.BUSYWAIT, 1'b1);
`ifdef ICACHE_STATS_EN
    check("reset hit_count", bus.HIT_COUNT, 16'd0);
    check("reset miss_count", bus.MISS_COUNT, 16'd0);
`endif
    rst = 1'b0;

    // Cold miss on line 0, memory busy 5 cycles.
    do_fill("cold", 6'h00, 5, D0, 1'b0);

    // Hits in the filled line, including ignored upper and low PC bits.
    for (int i = 0; i < 6; i++) begin
      apply_vec($sformatf("hit vec%0d", i), vecs[i]);
`ifdef ICACHE_STATS_EN
      if (i == 3) begin
        check("stats hit_count", bus.HIT_COUNT, 16'd4);
        check("stats miss_count", bus.MISS_COUNT, 16'd1);
      end
`endif
    end

    // Conflict: PC 0x080 maps to index 0 with tag 1 and evicts line 0.
    bus.PC = 32'h0000_0080;
    do_fill("conflict", 6'h08, 3, D1, 1'b0);
    apply_vec("conflict hit", '{32'h0000_0084, 1'b0, 32'hA1A1A1A1});
    bus.PC = 32'h0000_0000;
    do_fill("refill", 6'h00, 2, D0, 1'b0);
    apply_vec("refill hit", '{32'h0000_000C, 1'b0, 32'h0C0C0C0C});

    // Reset during the 3rd MEM_RD cycle while memory offers data.
    bus.PC = 32'h0000_0014;
    #1;
    check("midfill detect busywait", bus.BUSYWAIT, 1'b1);
    step();
    check("midfill mem_read", bus.MEM_READ, 1'b1);
    check("midfill mem_address", bus.MEM_ADDRESS, 6'h01);
    step();
    step();
    rst              = 1'b1;
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    step();
    check("midfill reset mem_read", bus.MEM_READ, 1'b0);
    check("midfill reset mem_address", bus.MEM_ADDRESS, 6'h00);
    check("midfill reset instruction", bus.INSTRUCTION, 32'h0);
    check("midfill reset busywait", bus.BUSYWAIT, 1'b1);
    rst              = 1'b0;
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = '0;
    #1;
    check("abandoned line still misses", bus.BUSYWAIT, 1'b1);
    bus.PC = 32'h0000_0004;
    #1;
    check("post reset 0x004 busywait", bus.BUSYWAIT, 1'b1);
    check("post reset 0x004 instruction", bus.INSTRUCTION, 32'h0);
    do_fill("post reset", 6'h00, 2, D0, 1'b0);
    apply_vec("post reset hit", '{32'h0000_0004, 1'b0, 32'h04040404});

    // Long stall: 20 busy memory cycles while PC[1:0] wiggles.
    bus.PC = 32'h0000_0040;
    do_fill("stall", 6'h04, 20, D4, 1'b1);
    apply_vec("stall hit", '{32'h0000_0048, 1'b0, 32'h44440002});

    // Single-cycle memory: MEM_BUSYWAIT already 0 on the first MEM_RD cycle.
    bus.PC = 32'h0000_03F0;
    do_fill("single", 6'h3F, 0, D7, 1'b0);
    apply_vec("single hit", '{32'h0000_03FC, 1'b0, 32'h7777000F});

    // Other indices were left untouched by these fills.
    apply_vec("line0 retained", '{32'h0000_0008, 1'b0, 32'h08080808});
    apply_vec("line4 retained", '{32'h0000_0040, 1'b0, 32'h44440000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
